// File: rtl/fpcvt_pkg.sv
// Shared constants and width helpers for the fixed-point to compact float converter.
package fpcvt_pkg;

    localparam logic [1:0] RND_TRUNC  = 2'b00;
    localparam logic [1:0] RND_HALFUP = 2'b01;
    localparam logic [1:0] RND_RNE    = 2'b10;

    function automatic int out_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic int e_max(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    function automatic int f_max(input int man_w);
        return (1 << man_w) - 1;
    endfunction

    // Holds bitlen 0..in_w and the raw exponent after a rounding carry.
    function automatic int er_w(input int in_w);
        return $clog2(in_w + 2);
    endfunction

endpackage

// File: rtl/fpcvt_lzc.sv
// Leading-one detector: returns bit length of an unsigned magnitude (0 for zero).
module fpcvt_lzc #(
    parameter int IN_W = 12,
    parameter int LW   = 4
) (
    input  logic [IN_W-1:0] mag,
    output logic [LW-1:0]   len
);

    // Highest set bit wins because the scan runs upward.
    always_comb begin
        len = {LW{1'b0}};
        for (int i = 0; i < IN_W; i++) begin
            len = mag[i] ? LW'(i + 1) : len;
        end
    end

endmodule

// File: rtl/fpcvt_pipe.sv
// Three-stage valid/ready converter from signed fixed-point to {S, E, F} words
// with per-sample rounding, saturation flag and saturation event counter.
module fpcvt_pipe
    import fpcvt_pkg::*;
#(
    parameter int IN_W  = 12,
    parameter int EXP_W = 3,
    parameter int MAN_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [IN_W-1:0]                  in_data,
    input  logic [1:0]                       in_rnd,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [out_w(EXP_W, MAN_W)-1:0]   out_data,
    output logic                             out_sat,
    output logic [CNT_W-1:0]                 sat_cnt,
    input  logic                             sat_clr
);

    localparam int OW    = out_w(EXP_W, MAN_W);
    localparam int ER_W  = er_w(IN_W);
    localparam int E_MAX = e_max(EXP_W);
    localparam int F_MAX = f_max(MAN_W);
    localparam int FW    = MAN_W + 1;

    logic              en_s;
    logic              v1_q, v1_d, s1_q, s1_d;
    logic [IN_W-1:0]   m1_q, m1_d;
    logic [1:0]        rnd1_q, rnd1_d;
    logic              v2_q, v2_d, s2_q, s2_d, g2_q, g2_d, st2_q, st2_d;
    logic [ER_W-1:0]   er2_q, er2_d, er_m1_s, len_s;
    logic [MAN_W-1:0]  f2_q, f2_d, f3_s;
    logic [1:0]        rnd2_q, rnd2_d;
    logic              out_valid_q, out_valid_d, out_sat_q, out_sat_d, inc_s;
    logic [OW-1:0]     out_data_q, out_data_d;
    logic [FW-1:0]     fsum_s;
    logic [ER_W-1:0]   e3_s;
    logic [CNT_W-1:0]  sat_cnt_q, sat_cnt_d;

    assign en_s      = !out_valid_q || out_ready;
    assign in_ready  = en_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign sat_cnt   = sat_cnt_q;

    fpcvt_lzc #(.IN_W(IN_W), .LW(ER_W)) u_lzc (
        .mag (m1_q),
        .len (len_s)
    );

    // Stage 1: sign and magnitude; the most negative input maps to 2^(IN_W-1) unsigned.
    always_comb begin
        v1_d   = in_valid;
        s1_d   = in_data[IN_W-1];
        rnd1_d = in_rnd;
        if (in_data[IN_W-1]) begin
            m1_d = ~in_data + IN_W'(1);
        end else begin
            m1_d = in_data;
        end
    end

    // Stage 2: raw exponent, truncated significand, guard and sticky bits.
    always_comb begin
        v2_d   = v1_q;
        s2_d   = s1_q;
        rnd2_d = rnd1_q;
        if (len_s > ER_W'(MAN_W)) begin
            er2_d = len_s - ER_W'(MAN_W);
        end else begin
            er2_d = {ER_W{1'b0}};
        end
        er_m1_s = er2_d - ER_W'(1);
        f2_d    = MAN_W'(m1_q >> er2_d);
        if (er2_d != {ER_W{1'b0}}) begin
            g2_d  = |(m1_q & (IN_W'(1) << er_m1_s));
            st2_d = |(m1_q & ((IN_W'(1) << er_m1_s) - IN_W'(1)));
        end else begin
            g2_d  = 1'b0;
            st2_d = 1'b0;
        end
    end

    // Stage 3: rounding, mantissa carry into the exponent, saturation, counter.
    always_comb begin
        case (rnd2_q)
            RND_TRUNC: inc_s = 1'b0;
            RND_RNE:   inc_s = g2_q && (st2_q || f2_q[0]);
            default:   inc_s = g2_q;
        endcase
        fsum_s = {1'b0, f2_q} + FW'(inc_s);
        if (fsum_s[MAN_W]) begin
            f3_s = MAN_W'(1) << (MAN_W - 1);
            e3_s = er2_q + ER_W'(1);
        end else begin
            f3_s = fsum_s[MAN_W-1:0];
            e3_s = er2_q;
        end
        out_valid_d = v2_q;
        if (32'(e3_s) > E_MAX) begin
            out_data_d = {s2_q, {EXP_W{1'b1}}, MAN_W'(F_MAX)};
            out_sat_d  = 1'b1;
        end else begin
            out_data_d = {s2_q, EXP_W'(e3_s), f3_s};
            out_sat_d  = 1'b0;
        end
        if (sat_clr) begin
            sat_cnt_d = {CNT_W{1'b0}};
        end else if (out_valid_q && out_ready && out_sat_q && (sat_cnt_q != {CNT_W{1'b1}})) begin
            sat_cnt_d = sat_cnt_q + CNT_W'(1);
        end else begin
            sat_cnt_d = sat_cnt_q;
        end
    end

    // Pipeline registers advance together; a stalled output freezes every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            s1_q        <= 1'b0;
            m1_q        <= {IN_W{1'b0}};
            rnd1_q      <= 2'b00;
            v2_q        <= 1'b0;
            s2_q        <= 1'b0;
            er2_q       <= {ER_W{1'b0}};
            f2_q        <= {MAN_W{1'b0}};
            g2_q        <= 1'b0;
            st2_q       <= 1'b0;
            rnd2_q      <= 2'b00;
            out_valid_q <= 1'b0;
            out_data_q  <= {OW{1'b0}};
            out_sat_q   <= 1'b0;
            sat_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            sat_cnt_q <= sat_cnt_d;
            if (en_s) begin
                v1_q        <= v1_d;
                s1_q        <= s1_d;
                m1_q        <= m1_d;
                rnd1_q      <= rnd1_d;
                v2_q        <= v2_d;
                s2_q        <= s2_d;
                er2_q       <= er2_d;
                f2_q        <= f2_d;
                g2_q        <= g2_d;
                st2_q       <= st2_d;
                rnd2_q      <= rnd2_d;
                out_valid_q <= out_valid_d;
                out_data_q  <= out_data_d;
                out_sat_q   <= out_sat_d;
            end
        end
    end

endmodule

// File: tb/tb_fpcvt_pipe.sv
// Self-checking bench for fpcvt_pipe: directed table, stall/drain, reset and random traffic.
module tb_fpcvt_pipe;

    localparam int IN_W  = 12;
    localparam int EXP_W = 3;
    localparam int MAN_W = 4;
    localparam int CNT_W = 16;
    localparam int OW    = 1 + EXP_W + MAN_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic [1:0]        in_rnd;
    logic              out_valid;
    logic              out_ready;
    logic [OW-1:0]     out_data;
    logic              out_sat;
    logic [CNT_W-1:0]  sat_cnt;
    logic              sat_clr;

    fpcvt_pipe #(.IN_W(IN_W), .EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_rnd    (in_rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .sat_cnt   (sat_cnt),
        .sat_clr   (sat_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_chk  = 0;
    int sat_seen = 0;

    task automatic chk(input string nm, input logic ok, input int act, input int exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    endtask

    typedef struct {
        logic [OW-1:0] d;
        logic          s;
        int            c;
        logic          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t mon_n;
    logic [OW-1:0] nx_d;
    logic          nx_s;
    logic          nx_lat;

    // Scoreboard: record accepted samples, compare every output transfer in order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("extra_output", 1'b0, int'(out_data), -1);
                end else begin
                    mon_e = sb.pop_front();
                    chk("out_data", out_data == mon_e.d, int'(out_data), int'(mon_e.d));
                    chk("out_sat", out_sat == mon_e.s, int'(out_sat), int'(mon_e.s));
                    if (mon_e.lat) chk("latency", (cyc - mon_e.c) == 3, cyc - mon_e.c, 3);
                    if (mon_e.s) sat_seen++;
                end
            end
            if (in_valid && in_ready) begin
                mon_n.d   = nx_d;
                mon_n.s   = nx_s;
                mon_n.c   = cyc;
                mon_n.lat = nx_lat;
                sb.push_back(mon_n);
            end
        end
    end

    // Reference conversion from the arithmetic definition: returns {sat, word}.
    function automatic logic [OW:0] model(input int v, input logic [1:0] r);
        int m, l, e, f, rem, half, w;
        logic g, s, inc, sat;
        m = (v < 0) ? -v : v;
        l = 0;
        for (int i = 0; i <= IN_W; i++) if (m >= (1 << i)) l = i + 1;
        e = (l > MAN_W) ? l - MAN_W : 0;
        f = m / (1 << e);
        rem = m % (1 << e);
        half = (e > 0) ? (1 << (e - 1)) : 1;
        g = (e > 0) && (rem >= half);
        s = (e > 1) && ((rem % half) != 0);
        if (r == 2'b00) inc = 1'b0;
        else if (r == 2'b10) inc = g && (s || (f % 2 == 1));
        else inc = g;
        f = f + (inc ? 1 : 0);
        if (f == (1 << MAN_W)) begin
            f = 1 << (MAN_W - 1);
            e = e + 1;
        end
        sat = e > ((1 << EXP_W) - 1);
        if (sat) begin
            e = (1 << EXP_W) - 1;
            f = (1 << MAN_W) - 1;
        end
        w = ((v < 0) ? (1 << (EXP_W + MAN_W)) : 0) + e * (1 << MAN_W) + f;
        return {sat, w[OW-1:0]};
    endfunction

    task automatic send(input logic [IN_W-1:0] d, input logic [1:0] r,
                        input logic [OW-1:0] ed, input logic es, input logic lat);
        logic acc;
        acc = 1'b0;
        nx_d = ed; nx_s = es; nx_lat = lat;
        in_data = d; in_rnd = r; in_valid = 1'b1;
        for (int i = 0; i < 500 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        if (!acc) chk("accept_timeout", 1'b0, 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [IN_W-1:0] d, input logic [1:0] r, input logic lat);
        logic [OW:0] m;
        m = model(int'($signed(d)), r);
        send(d, r, m[OW-1:0], m[OW], lat);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", sb.size() == 0, sb.size(), 0);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    typedef struct {
        logic [IN_W-1:0] d;
        logic [1:0]      r;
        logic [OW-1:0]   e;
        logic            s;
    } vec_t;

    vec_t tbl[15];
    logic [IN_W-1:0] stall_in[5];
    logic [1:0]      stall_rnd[5];
    logic [OW-1:0]   stall_ref;
    logic            done;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [OW:0] m;
        logic [IN_W-1:0] rd;
        logic acc, seen;
        int idx;

        tbl[0]  = '{12'd0,      2'b01, 8'h00, 1'b0};
        tbl[1]  = '{12'd56,     2'b01, 8'h2E, 1'b0};
        tbl[2]  = '{12'd422,    2'b01, 8'h5D, 1'b0};
        tbl[3]  = '{-12'sd422,  2'b01, 8'hDD, 1'b0};
        tbl[4]  = '{12'd42,     2'b00, 8'h2A, 1'b0};
        tbl[5]  = '{12'd42,     2'b01, 8'h2B, 1'b0};
        tbl[6]  = '{12'd42,     2'b10, 8'h2A, 1'b0};
        tbl[7]  = '{12'd46,     2'b10, 8'h2C, 1'b0};
        tbl[8]  = '{12'd31,     2'b01, 8'h28, 1'b0};
        tbl[9]  = '{12'd31,     2'b00, 8'h1F, 1'b0};
        tbl[10] = '{12'd2047,   2'b01, 8'h7F, 1'b1};
        tbl[11] = '{-12'sd2048, 2'b00, 8'hFF, 1'b1};
        tbl[12] = '{12'd2047,   2'b00, 8'h7F, 1'b0};
        tbl[13] = '{-12'sd1,    2'b00, 8'h81, 1'b0};
        tbl[14] = '{12'd46,     2'b11, 8'h2C, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_rnd = 2'b00;
        out_ready = 1'b1; sat_clr = 1'b0; done = 1'b0;
        nx_d = '0; nx_s = 1'b0; nx_lat = 1'b0;
        #22;
        chk("rst_out_valid", out_valid == 1'b0, int'(out_valid), 0);
        chk("rst_out_data", out_data == '0, int'(out_data), 0);
        chk("rst_out_sat", out_sat == 1'b0, int'(out_sat), 0);
        chk("rst_sat_cnt", sat_cnt == '0, int'(sat_cnt), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors, back-to-back, latency checked.
        for (int i = 0; i < 15; i++) send(tbl[i].d, tbl[i].r, tbl[i].e, tbl[i].s, 1'b1);
        drain();
        chk("sat_cnt_two", sat_cnt == 16'd2, int'(sat_cnt), 2);

        // Clear coincides with a third saturating output transfer.
        send(12'd2047, 2'b01, 8'h7F, 1'b1, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        chk("sat_out_seen", seen, int'(seen), 1);
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        chk("sat_clr_priority", sat_cnt == '0, int'(sat_cnt), 0);
        drain();
        chk("sat_cnt_after_clr", sat_cnt == '0, int'(sat_cnt), 0);

        // Stall: only three samples fit while the output is blocked.
        stall_in[0] = 12'd100;  stall_rnd[0] = 2'b01;
        stall_in[1] = -12'sd7;  stall_rnd[1] = 2'b00;
        stall_in[2] = 12'd1500; stall_rnd[2] = 2'b10;
        stall_in[3] = 12'd9;    stall_rnd[3] = 2'b01;
        stall_in[4] = -12'sd300; stall_rnd[4] = 2'b10;
        out_ready = 1'b0;
        idx = 0;
        for (int cy = 0; cy < 10; cy++) begin
            if (idx < 5) begin
                m = model(int'($signed(stall_in[idx])), stall_rnd[idx]);
                nx_d = m[OW-1:0]; nx_s = m[OW]; nx_lat = 1'b0;
                in_data = stall_in[idx]; in_rnd = stall_rnd[idx]; in_valid = 1'b1;
            end
            @(negedge clk);
            acc = in_ready && in_valid;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("stall_accepted", idx == 3, idx, 3);
        @(negedge clk);
        stall_ref = out_data;
        chk("stall_valid", out_valid == 1'b1, int'(out_valid), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready == 1'b0, int'(in_ready), 0);
            chk("stall_data_stable", out_data == stall_ref, int'(out_data), int'(stall_ref));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 3; i < 5; i++) send_m(stall_in[i], stall_rnd[i], 1'b0);
        drain();

        // Random traffic with random back-pressure.
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        sat_seen = 0;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        case ($urandom_range(0, 4))
                            0: rd = 12'd0;
                            1: rd = 12'd2047;
                            2: rd = 12'h800;
                            3: rd = 12'hFFF;
                            default: rd = 12'd1;
                        endcase
                    end else begin
                        rd = 12'($urandom);
                    end
                    send_m(rd, 2'($urandom_range(0, 3)), 1'b0);
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();
        chk("sat_cnt_random", int'(sat_cnt) == sat_seen, int'(sat_cnt), sat_seen);

        // Asynchronous reset while samples are in flight.
        send(12'd2047, 2'b01, 8'h7F, 1'b1, 1'b0);
        send(12'd56, 2'b01, 8'h2E, 1'b0, 1'b0);
        send(12'd422, 2'b01, 8'h5D, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid == 1'b0, int'(out_valid), 0);
        chk("async_rst_sat_cnt", sat_cnt == '0, int'(sat_cnt), 0);
        sb.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        send(12'd422, 2'b01, 8'h5D, 1'b0, 1'b1);
        drain();
        chk("final_empty", sb.size() == 0, sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
